// File: rtl/aes_inv_shift_rows_stage_if.sv
// aes_inv_shift_rows_stage_if: stream handshake bundle for the inverse ShiftRows stage
interface aes_inv_shift_rows_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  blk_cnt;
    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, blk_cnt
    );
    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, blk_cnt
    );
endinterface

// File: rtl/aes_inv_shift_rows_stage.sv
// aes_inv_shift_rows_stage: InvShiftRows plus optional round-key XOR feeding a 2-entry output FIFO
module aes_inv_shift_rows_stage #(
    parameter bit KEY_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    aes_inv_shift_rows_stage_if.slave   io_bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t       r_state;
    state_t       w_next;
    logic [127:0] r_head;
    logic [127:0] r_tail;
    logic [15:0]  r_cnt;
    logic [127:0] w_shift;
    logic [127:0] w_xf;
    logic         w_push;
    logic         w_pop;
    // out byte at column c, row r takes the input byte at column (c+3-r) mod 4, same row
    for (genvar b = 0; b < 16; b++) begin : g_map
        assign w_shift[8*b +: 8] = io_bus.in_data[8*(4*(((b/4)+3-(b%4))%4) + (b%4)) +: 8];
    end
    assign w_xf             = KEY_EN ? (w_shift ^ io_bus.in_key) : w_shift;
    assign io_bus.in_ready  = (r_state != TWO);
    assign io_bus.out_valid = (r_state != EMPTY);
    assign io_bus.out_data  = r_head;
    assign io_bus.blk_cnt   = r_cnt;
    assign w_push           = io_bus.in_valid && io_bus.in_ready;
    assign w_pop            = io_bus.out_valid && io_bus.out_ready;
    // FIFO occupancy next-state from push/pop
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_push ? ONE : EMPTY;
            ONE:     w_next = (w_push && !w_pop) ? TWO : ((!w_push && w_pop) ? EMPTY : ONE);
            TWO:     w_next = w_pop ? ONE : TWO;
            default: w_next = EMPTY;
        endcase
    end
    // state, head/tail storage and delivered-block counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop)
                r_cnt <= r_cnt + 16'd1;
            if (r_state == TWO && w_pop)
                r_head <= r_tail;
            else if (w_push && (r_state == EMPTY || w_pop))
                r_head <= w_xf;
            else if (w_push)
                r_tail <= w_xf;
        end
    end
endmodule

// File: tb/tb_aes_inv_shift_rows_stage.sv
// tb_aes_inv_shift_rows_stage: scoreboard bench driving KEY_EN=1 and KEY_EN=0 instances in lockstep
module tb_aes_inv_shift_rows_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_inv_shift_rows_stage_if bus1 ();
    aes_inv_shift_rows_stage_if bus0 ();

    aes_inv_shift_rows_stage #(.KEY_EN(1'b1)) u_k1 (.clk(clk), .rst(rst), .io_bus(bus1));
    aes_inv_shift_rows_stage #(.KEY_EN(1'b0)) u_k0 (.clk(clk), .rst(rst), .io_bus(bus0));

    int inv_src [16] = '{12, 9, 6, 3, 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15};

    logic [127:0] q1 [$];
    logic [127:0] q0 [$];
    logic [15:0]  exp_cnt = '0;
    int errors = 0;
    int checks = 0;

    localparam logic [127:0] D      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D_INV  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] D_INVF = 128'hfff2f5f8fbfef1f4f7fafdf0f3f6f9fc;

    function automatic logic [127:0] inv_sr(input logic [127:0] x);
        logic [127:0] y;
        for (int j = 0; j < 16; j++) y[8*j +: 8] = x[8*inv_src[j] +: 8];
        return y;
    endfunction

    function automatic logic [127:0] fwd_sr(input logic [127:0] x);
        logic [127:0] y;
        for (int j = 0; j < 16; j++) y[8*inv_src[j] +: 8] = x[8*j +: 8];
        return y;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [127:0] d, input logic [127:0] k,
                         input logic ordy, input bit rt = 1'b0, input logic [127:0] x = '0);
        bus1.in_valid = v; bus1.in_data = d; bus1.in_key = k; bus1.out_ready = ordy;
        bus0.in_valid = v; bus0.in_data = d; bus0.in_key = k; bus0.out_ready = ordy;
        if (v && bus1.in_ready && !rst) begin
            q1.push_back(rt ? x : (inv_sr(d) ^ k));
            q0.push_back(rt ? x : inv_sr(d));
        end
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic [127:0] k, input logic ordy);
        @(negedge clk);
        apply(v, d, k, ordy);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (q1.size() != 0 || q0.size() != 0); i++) drive(1'b0, '0, '0, 1'b1);
        after_edge();
        check({name, " q1 empty"}, 128'(q1.size()), 128'd0);
        check({name, " q0 empty"}, 128'(q0.size()), 128'd0);
    endtask

    // monitor: a transfer happens on the coming edge whenever out_valid && out_ready is seen here
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) check("k1 unexpected output", bus1.out_data, 128'hx);
                else check("k1 out_data", bus1.out_data, q1.pop_front());
                check("blk_cnt", 128'(bus1.blk_cnt), 128'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
            if (!rst && bus0.out_valid && bus0.out_ready) begin
                if (q0.size() == 0) check("k0 unexpected output", bus0.out_data, 128'hx);
                else check("k0 out_data", bus0.out_data, q0.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] b0, b1, b2, kk, x;
        b0 = 128'h00112233445566778899aabbccddeeff;
        b1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        b2 = 128'hdeadbeefcafef00d0123456789abcdef;
        kk = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
        rst = 1'b1;
        apply(1'b0, '0, '0, 1'b0);
        repeat (2) after_edge();
        check("reset out_valid", 128'(bus1.out_valid), 128'd0);
        check("reset in_ready", 128'(bus1.in_ready), 128'd1);
        check("reset out_data", bus1.out_data, 128'd0);
        check("reset blk_cnt", 128'(bus1.blk_cnt), 128'd0);

        // first edge after reset release accepts a block
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, D, '0, 1'b1);
        after_edge();
        check("latency out_valid", 128'(bus1.out_valid), 128'd1);
        check("vector k1 key0", bus1.out_data, D_INV);
        check("vector k0 key0", bus0.out_data, D_INV);
        drive(1'b1, D, '1, 1'b1);
        after_edge();
        check("blk_cnt after pop", 128'(bus1.blk_cnt), 128'd1);
        check("vector k1 keyff", bus1.out_data, D_INVF);
        check("vector k0 keyff", bus0.out_data, D_INV);
        drive(1'b0, '0, '0, 1'b1);
        after_edge();
        check("blk_cnt two pops", 128'(bus1.blk_cnt), 128'd2);
        check("empty out_valid", 128'(bus1.out_valid), 128'd0);

        // fill to TWO with downstream stalled; third block refused, head stable
        drive(1'b1, b0, kk, 1'b0);
        drive(1'b1, b1, kk, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b2, kk, 1'b0);
            after_edge();
            check("full in_ready", 128'(bus1.in_ready), 128'd0);
            check("full head stable", bus1.out_data, inv_sr(b0) ^ kk);
        end
        drive(1'b1, b2, kk, 1'b1);
        after_edge();
        check("after pop head", bus1.out_data, inv_sr(b1) ^ kk);
        drive(1'b1, b2, kk, 1'b1);
        after_edge();
        check("one push+pop out_valid", 128'(bus1.out_valid), 128'd1);
        check("one push+pop in_ready", 128'(bus1.in_ready), 128'd1);
        check("one push+pop head", bus1.out_data, inv_sr(b2) ^ kk);
        drain("full");

        // round trip through forward ShiftRows
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            apply(1'b1, fwd_sr(x), '0, 1'b1, 1'b1, x);
        end
        drain("roundtrip");

        // random valid/ready toggling
        for (int i = 0; i < 10000; i++)
            drive(1'(($urandom_range(0, 3)) != 0), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        drain("random");

        // reset while full with push and pop requested
        drive(1'b1, b0, kk, 1'b0);
        drive(1'b1, b1, kk, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        apply(1'b1, b2, kk, 1'b1);
        q1.delete();
        q0.delete();
        exp_cnt = '0;
        after_edge();
        check("rst out_valid", 128'(bus1.out_valid), 128'd0);
        check("rst in_ready", 128'(bus1.in_ready), 128'd1);
        check("rst blk_cnt", 128'(bus1.blk_cnt), 128'd0);
        check("rst out_data", bus1.out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, '0, '0, 1'b1);

        // 65536 deliveries wrap the counter back to zero
        for (int i = 0; i < 65536; i++) drive(1'b1, {4{i}}, '0, 1'b1);
        drain("wrap");
        check("blk_cnt wrap", 128'(bus1.blk_cnt), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
